// File: rtl/vga_capture_if.sv
// vga_capture_if: VGA pins into the capture block and its recovered pixel/status outputs
//   hsync, vsync, red, green, blue : source side (driven by the master)
//   pix_valid, pix_x, pix_y, pix_rgb : recovered active-area pixel stream
//   frame_done, frame_ok, frame_sum : per-frame report
//   locked, h_err, v_err : timing lock and error pulses
interface vga_capture_if;
    logic        hsync;
    logic        vsync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [11:0] pix_rgb;
    logic        frame_done;
    logic        frame_ok;
    logic [15:0] frame_sum;
    logic        locked;
    logic        h_err;
    logic        v_err;
    modport master (
        output hsync, vsync, red, green, blue,
        input  pix_valid, pix_x, pix_y, pix_rgb, frame_done, frame_ok, frame_sum, locked, h_err, v_err
    );
    modport slave (
        input  hsync, vsync, red, green, blue,
        output pix_valid, pix_x, pix_y, pix_rgb, frame_done, frame_ok, frame_sum, locked, h_err, v_err
    );
endinterface

// File: rtl/vga_capture.sv
// vga_capture: passive VGA sink recovering pixel coordinates, checking timing, checksumming frames
//   clk   : pixel clock, one pixel per cycle
//   reset : synchronous, active-high
//   vif   : slave side of vga_capture_if (sync/RGB in, pixel stream and frame status out)
module vga_capture #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input logic          clk,
    input logic          reset,
    vga_capture_if.slave vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] H_LO   = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_HI   = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [10:0] V_LO   = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_HI   = 11'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_SW   = 11'(H_SYNC);
    localparam logic [10:0] C_MAX  = '1;
    typedef enum logic [1:0] {UNLOCKED, ONE_GOOD, LOCKED} lock_t;
    logic        hs1, hs2, vs1, vs2;
    logic [11:0] rgb1;
    logic [10:0] h_cnt, v_cnt, hw_cnt;
    logic        seen_h, seen_v, v_pend, err_flag;
    logic [15:0] acc;
    lock_t       state, state_nx;
    logic        hs_edge, vs_edge, v_edge, line_bad, frame_bad, in_act;
    logic [10:0] h_nx, v_nx, hw_nx;
    // Counters describe the pixel currently held in stage 1.
    // v_pend remembers a vsync edge until the hsync edge that qualifies it.
    always_comb begin
        hs_edge   = (hs1 == SYNC_POL) && (hs2 != SYNC_POL);
        vs_edge   = (vs1 == SYNC_POL) && (vs2 != SYNC_POL);
        v_edge    = hs_edge && (v_pend || vs_edge);
        h_nx      = hs_edge ? '0 : (h_cnt == C_MAX ? h_cnt : h_cnt + 11'd1);
        v_nx      = !hs_edge ? v_cnt : v_edge ? '0 : (v_cnt == C_MAX ? v_cnt : v_cnt + 11'd1);
        hw_nx     = hs_edge ? 11'd1 : (hs1 == SYNC_POL && hw_cnt != C_MAX) ? hw_cnt + 11'd1 : hw_cnt;
        line_bad  = hs_edge && seen_h && (h_cnt != H_LAST || hw_cnt != H_SW);
        frame_bad = v_edge && seen_v && v_cnt != V_LAST;
        in_act    = seen_v && h_nx >= H_LO && h_nx <= H_HI && v_nx >= V_LO && v_nx <= V_HI;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            hs1            <= ~SYNC_POL;
            hs2            <= ~SYNC_POL;
            vs1            <= ~SYNC_POL;
            vs2            <= ~SYNC_POL;
            rgb1           <= '0;
            h_cnt          <= '0;
            v_cnt          <= '0;
            hw_cnt         <= '0;
            seen_h         <= 1'b0;
            seen_v         <= 1'b0;
            v_pend         <= 1'b0;
            err_flag       <= 1'b0;
            acc            <= '0;
            vif.pix_valid  <= 1'b0;
            vif.pix_x      <= '0;
            vif.pix_y      <= '0;
            vif.pix_rgb    <= '0;
            vif.frame_done <= 1'b0;
            vif.frame_ok   <= 1'b0;
            vif.frame_sum  <= '0;
            vif.h_err      <= 1'b0;
            vif.v_err      <= 1'b0;
        end else begin
            hs1            <= vif.hsync;
            hs2            <= hs1;
            vs1            <= vif.vsync;
            vs2            <= vs1;
            rgb1           <= {vif.red, vif.green, vif.blue};
            h_cnt          <= h_nx;
            v_cnt          <= v_nx;
            hw_cnt         <= hw_nx;
            seen_h         <= seen_h | hs_edge;
            seen_v         <= seen_v | v_edge;
            v_pend         <= hs_edge ? 1'b0 : v_pend | vs_edge;
            err_flag       <= v_edge ? 1'b0 : err_flag | line_bad;
            // A pixel landing on the frame boundary belongs to the new frame.
            acc            <= (v_edge ? 16'd0 : acc) + (vif.pix_valid ? 16'(vif.pix_rgb) : 16'd0);
            vif.pix_valid  <= in_act;
            vif.frame_done <= v_edge && seen_v;
            vif.h_err      <= line_bad;
            vif.v_err      <= frame_bad;
            if (in_act) begin
                vif.pix_x   <= 10'(h_nx - H_LO);
                vif.pix_y   <= 10'(v_nx - V_LO);
                vif.pix_rgb <= rgb1;
            end
            if (v_edge && seen_v) begin
                vif.frame_ok  <= !(err_flag || line_bad || frame_bad);
                vif.frame_sum <= acc;
            end
        end
    end
    always_ff @(posedge clk) state <= reset ? UNLOCKED : state_nx;
    always_comb begin
        state_nx = state;
        if (vif.h_err || vif.v_err || (vif.frame_done && !vif.frame_ok))
            state_nx = UNLOCKED;
        else if (vif.frame_done)
            state_nx = (state == UNLOCKED) ? ONE_GOOD : LOCKED;
    end
    always_comb vif.locked = (state == LOCKED);
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: random-pixel VGA source with a frame-level reference model, two polarities in parallel
module tb_vga_capture;
    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    typedef struct packed {
        logic        valid;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
        logic        done;
        logic        ok;
        logic [15:0] sum;
        logic        herr;
        logic        verr;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rst_q = 1'b1;
    exp_t e_pin = '0, e_d1 = '0, e_d2 = '0;
    int n_chk = 0, n_fail = 0;
    int streak = 0;
    logic exp_lock = 1'b0;
    logic seen_h_m, seen_v_m, prev_bad, err_m;
    logic [15:0] acc_m;
    int nl, fixed_rgb;
    always #5 clk = ~clk;
    vga_capture_if vif0 ();
    vga_capture_if vif1 ();
    vga_capture #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
                  .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)) dut0 (.clk(clk), .reset(reset), .vif(vif0));
    vga_capture #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
                  .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)) dut1 (.clk(clk), .reset(reset), .vif(vif1));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // Two-cycle pin-to-output latency; reset flushes whatever was in flight.
    always @(posedge clk) begin
        rst_q <= reset;
        e_d1  <= reset ? exp_t'(0) : e_pin;
        e_d2  <= reset ? exp_t'(0) : e_d1;
    end
    task automatic mon(input int id, input logic pv, input logic [9:0] px, input logic [9:0] py,
                       input logic [11:0] prgb, input logic fd, input logic fo, input logic [15:0] fs,
                       input logic lk, input logic he, input logic ve);
        string p;
        p = $sformatf("u%0d.", id);
        check({p, "pix_valid"}, 32'(pv), 32'(e_d2.valid));
        check({p, "frame_done"}, 32'(fd), 32'(e_d2.done));
        check({p, "h_err"}, 32'(he), 32'(e_d2.herr));
        check({p, "v_err"}, 32'(ve), 32'(e_d2.verr));
        check({p, "locked"}, 32'(lk), 32'(exp_lock));
        if (e_d2.valid || rst_q) begin
            check({p, "pix_x"}, 32'(px), 32'(e_d2.x));
            check({p, "pix_y"}, 32'(py), 32'(e_d2.y));
            check({p, "pix_rgb"}, 32'(prgb), 32'(e_d2.rgb));
        end
        if (e_d2.done || rst_q) begin
            check({p, "frame_ok"}, 32'(fo), 32'(e_d2.ok));
            check({p, "frame_sum"}, 32'(fs), 32'(e_d2.sum));
        end
    endtask
    // Lock is two consecutive good frames with no error pulse in between.
    initial forever begin
        @(negedge clk);
        if (rst_q) begin
            streak   = 0;
            exp_lock = 1'b0;
        end
        mon(0, vif0.pix_valid, vif0.pix_x, vif0.pix_y, vif0.pix_rgb, vif0.frame_done, vif0.frame_ok,
            vif0.frame_sum, vif0.locked, vif0.h_err, vif0.v_err);
        mon(1, vif1.pix_valid, vif1.pix_x, vif1.pix_y, vif1.pix_rgb, vif1.frame_done, vif1.frame_ok,
            vif1.frame_sum, vif1.locked, vif1.h_err, vif1.v_err);
        if (e_d2.herr || e_d2.verr) streak = 0;
        if (e_d2.done) streak = e_d2.ok ? streak + 1 : 0;
        exp_lock = (streak >= 2);
    end
    task automatic drive(input logic ha, input logic va, input logic [11:0] rgb, input exp_t r, input logic rst);
        @(posedge clk);
        #1;
        reset = rst;
        vif0.hsync = ~ha;
        vif0.vsync = ~va;
        vif1.hsync = ha;
        vif1.vsync = va;
        {vif0.red, vif0.green, vif0.blue} = rgb;
        {vif1.red, vif1.green, vif1.blue} = rgb;
        e_pin = r;
    endtask
    task automatic clear_model();
        seen_h_m = 1'b0;
        seen_v_m = 1'b0;
        prev_bad = 1'b0;
        err_m    = 1'b0;
        acc_m    = '0;
        nl       = 0;
    endtask
    // One frame of nlines lines; optional stretched line, widened hsync line, or 3-clock reset mid-line.
    task automatic frame(input int nlines, input int long_line, input int wide_line, input int rst_line);
        exp_t r;
        logic [11:0] rgb;
        int len, w, rst_cnt;
        rst_cnt = 0;
        for (int l = 0; l < nlines; l++) begin
            len = (l == long_line) ? HT + 1 : HT;
            w   = (l == wide_line) ? HS + 1 : HS;
            for (int h = 0; h < len; h++) begin
                r   = '0;
                rgb = (fixed_rgb >= 0) ? 12'(fixed_rgb) : 12'($urandom);
                if (h == 0) begin
                    if (seen_h_m && prev_bad) begin
                        r.herr = 1'b1;
                        err_m  = 1'b1;
                    end
                    if (l == 0) begin
                        if (seen_v_m) begin
                            r.verr = (nl != VT);
                            r.done = 1'b1;
                            r.ok   = !(err_m || r.verr);
                            r.sum  = acc_m;
                        end
                        seen_v_m = 1'b1;
                        acc_m    = '0;
                        err_m    = 1'b0;
                        nl       = 0;
                    end
                    seen_h_m = 1'b1;
                    nl++;
                    prev_bad = (len != HT) || (w != HS);
                end
                if (seen_v_m && l >= VS + VB && l < VS + VB + VA && h >= HS + HB && h < HS + HB + HA) begin
                    r.valid = 1'b1;
                    r.x     = 10'(h - HS - HB);
                    r.y     = 10'(l - VS - VB);
                    r.rgb   = rgb;
                    acc_m   = acc_m + 16'(rgb);
                end
                if (l == rst_line && h == HS + HB + 5) rst_cnt = 3;
                if (rst_cnt > 0) begin
                    clear_model();
                    r = '0;
                end
                drive(h < w, l < VS, rgb, r, rst_cnt > 0);
                if (rst_cnt > 0) rst_cnt--;
            end
        end
    endtask
    initial begin
        clear_model();
        fixed_rgb = 1;
        vif0.hsync = 1'b1;
        vif0.vsync = 1'b1;
        vif1.hsync = 1'b0;
        vif1.vsync = 1'b0;
        {vif0.red, vif0.green, vif0.blue} = '0;
        {vif1.red, vif1.green, vif1.blue} = '0;
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 12'h0, exp_t'(0), 1'b1);
        repeat (3) frame(VT, -1, -1, -1);
        fixed_rgb = -1;
        repeat (2) frame(VT, -1, -1, -1);
        frame(VT, 5, -1, -1);
        repeat (2) frame(VT, -1, -1, -1);
        frame(VT - 1, -1, -1, -1);
        repeat (2) frame(VT, -1, -1, -1);
        frame(VT, -1, -1, 8);
        repeat (3) frame(VT, -1, -1, -1);
        frame(VT, -1, 7, -1);
        repeat (2) frame(VT, -1, -1, -1);
        frame(1, -1, -1, -1);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 12'h0, exp_t'(0), 1'b0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
